// File: rtl/mul_seq.sv
// Repeated-addition multiplier sequencer: loads A then B, adds A into P once per count.
// Latency: N+2 edges from the start-sampling edge to done; done is a one-cycle pulse.
// No backpressure: start is only looked at in IDLE, requests elsewhere are dropped.
module mul_seq #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   data_in,
   input  logic               eqz,
   output logic [WIDTH-1:0]   b_cnt,
   output logic [2*WIDTH-1:0] product,
   output logic               busy,
   output logic               done
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_B = 3'd1,
      CALC   = 3'd2,
      DONE   = 3'd3
   } state_t;

   state_t             state;
   logic [WIDTH-1:0]   a;
   logic [2*WIDTH-1:0] p;

   assign product = p;

   // Sequencer: operand capture, add/decrement loop, and registered busy/done flags.
   // The loop ends only on the external eqz flag; b_cnt is never compared here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         a     <= '0;
         b_cnt <= '0;
         p     <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               busy <= 1'b0;
               if (start) begin
                  a     <= data_in;
                  busy  <= 1'b1;
                  state <= LOAD_B;
               end
            end
            LOAD_B: begin
               b_cnt <= data_in;
               p     <= '0;
               busy  <= 1'b1;
               state <= CALC;
            end
            CALC: begin
               if (!eqz) begin
                  p     <= p + {{WIDTH{1'b0}}, a};
                  b_cnt <= b_cnt - WIDTH'(1);
               end else begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
